axis_pkt_gen: RTL and testbench

//  AXI-Stream packet transmitter: the source end that feeds queue / stream_fifo m_* inputs.

---
 rtl/axis_pkt_gen_if.sv | 12 +
 rtl/axis_pkt_gen.sv | 169 ++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream link between the packet generator (master) and its sink (slave).
interface axis_pkt_gen_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: bursts of counting-payload packets with TLAST per packet and
// optional idle gaps, tolerant of arbitrary backpressure and mid-run abort.
module axis_pkt_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16,
   parameter int GAP_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [CNT_WIDTH-1:0]  num_pkts,
   input  logic [GAP_WIDTH-1:0]  gap,
   input  logic [DATA_WIDTH-1:0] seed,
   axis_pkt_gen_if.master        m,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  pkt_sent
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [GAP_WIDTH-1:0]  GAP_ZERO  = {GAP_WIDTH{1'b0}};

   state_t                state_r, state_nxt_s;
   logic [LEN_WIDTH-1:0]  len_m1_r, len_m1_nxt_s;
   logic [CNT_WIDTH-1:0]  num_r, num_nxt_s;
   logic [GAP_WIDTH-1:0]  gap_r, gap_nxt_s;
   logic [GAP_WIDTH-1:0]  gap_cnt_r, gap_cnt_nxt_s;
   logic [LEN_WIDTH-1:0]  beat_idx_r, beat_idx_nxt_s;
   logic [DATA_WIDTH-1:0] data_r, data_nxt_s;
   logic [CNT_WIDTH-1:0]  sent_r, sent_nxt_s;
   logic                  tvalid_r, tlast_r, tlast_nxt_s;
   logic                  busy_r, done_r;
   logic                  abort_pend_r, abort_pend_nxt_s;
   logic                  fire_s, abort_s, launch_s, last_pkt_s;

   assign fire_s     = tvalid_r && m.tready;
   // An abort seen during a stall is remembered until the pending beat is accepted.
   assign abort_s    = abort || abort_pend_r;
   assign launch_s   = (state_r == ST_IDLE) && start;
   assign last_pkt_s = ((sent_r + CNT_ONE) == num_r);

   assign m.tdata  = data_r;
   assign m.tvalid = tvalid_r;
   assign m.tlast  = tlast_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign pkt_sent = sent_r;

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         len_m1_r     <= LEN_ZERO;
         num_r        <= CNT_ZERO;
         gap_r        <= GAP_ZERO;
         gap_cnt_r    <= GAP_ZERO;
         beat_idx_r   <= LEN_ZERO;
         data_r       <= DATA_ZERO;
         sent_r       <= CNT_ZERO;
         tvalid_r     <= 1'b0;
         tlast_r      <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         abort_pend_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         len_m1_r     <= len_m1_nxt_s;
         num_r        <= num_nxt_s;
         gap_r        <= gap_nxt_s;
         gap_cnt_r    <= gap_cnt_nxt_s;
         beat_idx_r   <= beat_idx_nxt_s;
         data_r       <= data_nxt_s;
         sent_r       <= sent_nxt_s;
         tvalid_r     <= (state_nxt_s == ST_SEND);
         tlast_r      <= tlast_nxt_s;
         busy_r       <= (state_nxt_s == ST_SEND) || (state_nxt_s == ST_GAP);
         done_r       <= (state_nxt_s == ST_DONE);
         abort_pend_r <= abort_pend_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = (num_pkts == CNT_ZERO) ? ST_DONE : ST_SEND;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (!fire_s) begin
               state_nxt_s = ST_SEND;
            end else if (abort_s || (tlast_r && last_pkt_s)) begin
               state_nxt_s = ST_DONE;
            end else if (tlast_r && (gap_r != GAP_ZERO)) begin
               state_nxt_s = ST_GAP;
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nxt_s = ST_DONE;
            end else if (gap_cnt_r == GAP_ONE) begin
               state_nxt_s = ST_SEND;
            end else begin
               state_nxt_s = ST_GAP;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the datapath and output registers.
   always_comb begin
      len_m1_nxt_s   = len_m1_r;
      num_nxt_s      = num_r;
      gap_nxt_s      = gap_r;
      if (launch_s) begin
         len_m1_nxt_s = (pkt_len == LEN_ZERO) ? LEN_ZERO : (pkt_len - LEN_ONE);
         num_nxt_s    = num_pkts;
         gap_nxt_s    = gap;
      end else begin
         len_m1_nxt_s = len_m1_r;
      end

      data_nxt_s     = launch_s ? seed : (fire_s ? (data_r + DATA_ONE) : data_r);
      beat_idx_nxt_s = launch_s ? LEN_ZERO
                     : (fire_s ? (tlast_r ? LEN_ZERO : (beat_idx_r + LEN_ONE)) : beat_idx_r);
      sent_nxt_s     = launch_s ? CNT_ZERO : ((fire_s && tlast_r) ? (sent_r + CNT_ONE) : sent_r);

      if ((state_r == ST_SEND) && (state_nxt_s == ST_GAP)) begin
         gap_cnt_nxt_s = gap_r;
      end else if (state_r == ST_GAP) begin
         gap_cnt_nxt_s = gap_cnt_r - GAP_ONE;
      end else begin
         gap_cnt_nxt_s = gap_cnt_r;
      end

      if ((state_r == ST_SEND) && !fire_s && abort) begin
         abort_pend_nxt_s = 1'b1;
      end else if ((state_r != ST_SEND) || fire_s) begin
         abort_pend_nxt_s = 1'b0;
      end else begin
         abort_pend_nxt_s = abort_pend_r;
      end

      tlast_nxt_s = (state_nxt_s == ST_SEND) && (beat_idx_nxt_s == len_m1_nxt_s);
   end
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen: counting payload, TLAST placement, gaps, backpressure,
// wrap-around, abort under stall, empty runs and mid-run reset.
module tb_axis_pkt_gen;
   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [7:0]  pkt_len;
   logic [15:0] num_pkts;
   logic [3:0]  gap;
   logic [31:0] seed;
   logic        busy, done;
   logic [15:0] pkt_sent;

   int checks = 0;
   int errors = 0;

   logic [31:0] dq[$];
   logic        lq[$];
   logic        vq[$];
   int          stall_err, last_beat_cyc, done_cyc;

   axis_pkt_gen_if #(.DATA_WIDTH(32)) s ();

   axis_pkt_gen #(.DATA_WIDTH(32), .LEN_WIDTH(8), .CNT_WIDTH(16), .GAP_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .pkt_len(pkt_len),
      .num_pkts(num_pkts), .gap(gap), .seed(seed), .m(s), .busy(busy), .done(done),
      .pkt_sent(pkt_sent)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [7:0] l, input logic [15:0] n, input logic [3:0] g,
                         input logic [31:0] sd);
      pkt_len = l; num_pkts = n; gap = g; seed = sd; start = 1'b1;
      tick();
      start = 1'b0;
      pkt_len = 8'hAA; num_pkts = 16'h00FF; gap = 4'hF; seed = 32'hDEAD_BEEF;
   endtask

   // Runs until done (or budget), logging accepted beats and tvalid per cycle.
   task automatic run(input int budget, input bit rand_ready);
      logic        pv, pl, seen;
      logic [31:0] pd;
      dq.delete(); lq.delete(); vq.delete();
      stall_err = 0; pv = 1'b0; pl = 1'b0; pd = 32'h0; seen = 1'b0;
      last_beat_cyc = -1; done_cyc = -1;
      for (int cyc = 0; cyc < budget && !seen; cyc++) begin
         if (pv && (s.tvalid !== 1'b1 || s.tdata !== pd || s.tlast !== pl)) stall_err++;
         s.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         vq.push_back(s.tvalid);
         if (s.tvalid && s.tready) begin
            dq.push_back(s.tdata);
            lq.push_back(s.tlast);
            last_beat_cyc = cyc;
         end
         pv = s.tvalid && !s.tready; pd = s.tdata; pl = s.tlast;
         if (done) begin
            seen = 1'b1;
            done_cyc = cyc;
         end
         tick();
      end
      check("run_done_seen", 32'(seen), 32'd1);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   task automatic check_stream(input string tag, input int n, input logic [31:0] base,
                               input int plen);
      check({tag, "_beats"}, 32'(dq.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         check({tag, "_data"}, dq[i], base + 32'(i));
         check({tag, "_last"}, 32'(lq[i]), 32'((i % plen) == plen - 1));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; s.tready = 1'b1;
      pkt_len = 8'd0; num_pkts = 16'd0; gap = 4'd0; seed = 32'd0;
      tick(); tick();
      check("rst_tvalid", 32'(s.tvalid), 32'd0);
      check("rst_tlast", 32'(s.tlast), 32'd0);
      check("rst_tdata", s.tdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pkt_sent", 32'(pkt_sent), 32'd0);
      rst = 1'b0;
      tick();

      // abort in IDLE does nothing
      abort = 1'b1; tick(); abort = 1'b0;
      check("idle_abort_done", 32'(done), 32'd0);
      check("idle_abort_busy", 32'(busy), 32'd0);

      // T1: back-to-back packets, ready always high
      launch(8'd4, 16'd2, 4'd0, 32'h10);
      check("t1_latency_tvalid", 32'(s.tvalid), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      run(100, 1'b0);
      check_stream("t1", 8, 32'h10, 4);
      check("t1_consecutive", 32'(last_beat_cyc), 32'd7);
      check("t1_done_after_last", 32'(done_cyc - last_beat_cyc), 32'd1);
      check("t1_pkt_sent", 32'(pkt_sent), 32'd2);
      check("t1_idle_busy", 32'(busy), 32'd0);

      // T2: gap of two idle cycles between packets
      launch(8'd3, 16'd2, 4'd2, 32'h0);
      run(100, 1'b0);
      check_stream("t2", 6, 32'h0, 3);
      for (int i = 0; i < 8; i++) check("t2_valid_pattern", 32'(vq[i]), 32'(i < 3 || i >= 5));
      check("t2_pkt_sent", 32'(pkt_sent), 32'd2);

      // T3: T1 config under random backpressure
      launch(8'd4, 16'd2, 4'd0, 32'h10);
      run(400, 1'b1);
      check_stream("t3", 8, 32'h10, 4);
      check("t3_stall_stable", 32'(stall_err), 32'd0);
      check("t3_pkt_sent", 32'(pkt_sent), 32'd2);

      // T4: pkt_len 0 acts as 1, payload wraps
      launch(8'd0, 16'd3, 4'd0, 32'hFFFF_FFFE);
      run(100, 1'b0);
      check_stream("t4", 3, 32'hFFFF_FFFE, 1);
      check("t4_pkt_sent", 32'(pkt_sent), 32'd3);

      // T5: abort while beat 10 is stalled
      s.tready = 1'b1;
      launch(8'd8, 16'd4, 4'd0, 32'h0);
      repeat (10) tick();
      check("t5_pending_data", s.tdata, 32'd10);
      check("t5_pkt_sent_mid", 32'(pkt_sent), 32'd1);
      s.tready = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_stall_tvalid", 32'(s.tvalid), 32'd1);
      check("t5_stall_data", s.tdata, 32'd10);
      check("t5_stall_tlast", 32'(s.tlast), 32'd0);
      tick();
      check("t5_stall2_tvalid", 32'(s.tvalid), 32'd1);
      check("t5_stall2_data", s.tdata, 32'd10);
      s.tready = 1'b1;
      tick();
      check("t5_abort_tvalid", 32'(s.tvalid), 32'd0);
      check("t5_abort_done", 32'(done), 32'd1);
      check("t5_abort_pkt_sent", 32'(pkt_sent), 32'd1);
      tick();
      check("t5_done_pulse", 32'(done), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      launch(8'd4, 16'd0, 4'd0, 32'h0);
      check("t5_empty_done", 32'(done), 32'd1);
      check("t5_empty_tvalid", 32'(s.tvalid), 32'd0);
      check("t5_empty_pkt_sent", 32'(pkt_sent), 32'd0);
      tick();
      check("t5_empty_done_clr", 32'(done), 32'd0);

      // T6: reset during a stalled SEND, then a normal run
      s.tready = 1'b0;
      launch(8'd4, 16'd2, 4'd0, 32'h55);
      tick();
      check("t6_pre_tvalid", 32'(s.tvalid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_rst_tvalid", 32'(s.tvalid), 32'd0);
      check("t6_rst_tlast", 32'(s.tlast), 32'd0);
      check("t6_rst_tdata", s.tdata, 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      s.tready = 1'b1;
      launch(8'd4, 16'd2, 4'd0, 32'h10);
      run(100, 1'b0);
      check_stream("t6", 8, 32'h10, 4);
      check("t6_pkt_sent", 32'(pkt_sent), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
